// File: rtl/elbeth_load_store_unit.sv
// Load/store stage between EXS and the data memory port: aligns requests, drives strobes,
// extends load data, and raises misaligned/access faults (bus error or BUSY watchdog).
module elbeth_load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exs_mem_en,
  input  logic        exs_mem_rw,
  input  logic [1:0]  exs_mem_size,
  input  logic        exs_mem_signed,
  input  logic [31:0] exs_addr,
  input  logic [31:0] exs_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_en,
  output logic [3:0]  dmem_wr,
  output logic [31:0] dmem_out_data,
  input  logic [31:0] dmem_in_data,
  input  logic        dmem_ready,
  input  logic        dmem_error,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_stall,
  output logic        lsu_exc_misaligned_ld,
  output logic        lsu_exc_misaligned_st,
  output logic        lsu_exc_access,
  output logic [31:0] lsu_exc_addr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} state_t;
  typedef enum logic [1:0] {F_MIS_LD, F_MIS_ST, F_ACCESS} fault_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  fault_t      fault_q;
  logic [31:0] addr_q, daddr_q, odata_q, rdata_q, cnt_q;
  logic [3:0]  wr_q;
  logic [1:0]  size_q;
  logic        signed_q, rw_q;
  logic        misaligned, timeout;
  logic [3:0]  strobe;
  logic [31:0] repl, shifted, ext;

  always_comb begin
    misaligned = 1'b0;
    strobe     = 4'b1111;
    repl       = exs_wdata;
    case (exs_mem_size)
      2'b00: begin
        strobe = 4'b0001 << exs_addr[1:0];
        repl   = {4{exs_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = exs_addr[0];
        strobe     = 4'b0011 << exs_addr[1:0];
        repl       = {2{exs_wdata[15:0]}};
      end
      2'b10:   misaligned = (exs_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Extraction uses the latched offset/size; the memory word arrives while BUSY.
  always_comb begin
    shifted = dmem_in_data >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: ext = dmem_in_data;
    endcase
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (exs_mem_en) state_nxt = misaligned ? FAULT : BUSY;
      BUSY: begin
        if (dmem_ready)   state_nxt = dmem_error ? FAULT : DONE;
        else if (timeout) state_nxt = FAULT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q  <= F_MIS_LD;
      addr_q   <= '0;
      daddr_q  <= '0;
      odata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      rw_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_q <= '0;
          if (exs_mem_en) begin
            addr_q   <= exs_addr;
            size_q   <= exs_mem_size;
            signed_q <= exs_mem_signed;
            rw_q     <= exs_mem_rw;
            if (misaligned) begin
              fault_q <= exs_mem_rw ? F_MIS_ST : F_MIS_LD;
            end else begin
              daddr_q <= {exs_addr[31:2], 2'b00};
              wr_q    <= exs_mem_rw ? strobe : 4'b0000;
              odata_q <= repl;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 32'd1;
          if (dmem_ready && !dmem_error && !rw_q) rdata_q <= ext;
          if ((dmem_ready && dmem_error) || (!dmem_ready && timeout)) fault_q <= F_ACCESS;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign dmem_en               = (state == BUSY);
  assign dmem_addr             = daddr_q;
  assign dmem_wr               = dmem_en ? wr_q : 4'b0000;
  assign dmem_out_data         = odata_q;
  assign lsu_rdata             = rdata_q;
  assign lsu_done              = (state == DONE);
  assign lsu_stall             = exs_mem_en && (state != DONE) && (state != FAULT);
  assign lsu_exc_misaligned_ld = (state == FAULT) && (fault_q == F_MIS_LD);
  assign lsu_exc_misaligned_st = (state == FAULT) && (fault_q == F_MIS_ST);
  assign lsu_exc_access        = (state == FAULT) && (fault_q == F_ACCESS);
  assign lsu_exc_addr          = addr_q;

endmodule

// File: doc/elbeth_load_store_unit.md
Name: elbeth_load_store_unit

Overview:
Data-memory access stage between the core's EXS stage and the data memory port. It takes one load/store request per instruction from EXS and generates the word-aligned address, byte-lane write strobes and replicated store data. It runs the ready/error handshake with memory and sign- or zero-extends load data. It stalls the pipeline until the access resolves and reports misaligned and access faults, including a watchdog timeout.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive BUSY cycles without dmem_ready before an access fault; 0 disables the watchdog.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
exs_mem_en  in  1  request valid; held stable by EXS while lsu_stall=1
exs_mem_rw  in  1  1=store, 0=load
exs_mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved
exs_mem_signed  in  1  1=sign-extend load, 0=zero-extend
exs_addr  in  32  byte address (ALU result)
exs_wdata  in  32  store data (rs2)
dmem_addr  out  32  word address, {addr[31:2],2'b00}
dmem_en  out  1  memory request
dmem_wr  out  4  byte write strobes; 0000 for loads
dmem_out_data  out  32  store data, lane-replicated
dmem_in_data  in  32  load data word
dmem_ready  in  1  access complete
dmem_error  in  1  access error, valid with dmem_ready
lsu_rdata  out  32  extended load result, valid when lsu_done=1
lsu_done  out  1  one-cycle completion pulse
lsu_stall  out  1  pipeline hold request
lsu_exc_misaligned_ld  out  1  one-cycle pulse
lsu_exc_misaligned_st  out  1  one-cycle pulse
lsu_exc_access  out  1  one-cycle pulse: bus error or timeout
lsu_exc_addr  out  32  faulting byte address, valid with any exc pulse

Behaviour:
- Clock, reset: single clock clk; reset rst is synchronous, active-high. All state updates on posedge clk.
- Reset values: state=IDLE. dmem_en=0, dmem_wr=0, dmem_addr=0, dmem_out_data=0, lsu_rdata=0, lsu_done=0, all exc=0, lsu_exc_addr=0, watchdog counter=0.
- lsu_stall is combinational: exs_mem_en && state∉{DONE,FAULT}. It is 0 whenever exs_mem_en=0.
- Misaligned condition:
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]≠00
  - size=11, any address
- FSM states: IDLE, BUSY, DONE, FAULT.
- IDLE:
  - exs_mem_en=1 and aligned: latch request (word address, strobes, replicated data, size, signed, addr[1:0], full addr); go to BUSY.
  - exs_mem_en=1 and misaligned: latch addr; go to FAULT with the misaligned type. No memory request is issued.
- BUSY:
  - dmem_en=1 with latched outputs; counter increments each cycle.
  - dmem_ready=1 with dmem_error=0: register extended data into lsu_rdata (loads only); go to DONE.
  - dmem_ready=1 with dmem_error=1: go to FAULT (access).
  - No dmem_ready and counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): go to FAULT (access).
  - Ready in the same cycle as the timeout condition: ready wins.
  - dmem_en deasserts the cycle after exit.
- DONE: lsu_done=1 and stall=0 for one cycle, so EXS advances; then IDLE. lsu_rdata holds until the next load completes.
- FAULT: the selected exc pulse is 1 for one cycle with lsu_exc_addr, stall=0; then IDLE.
- Latency: for a zero-wait memory, request at cycle 0 (IDLE), dmem_en at cycle 1, lsu_done at cycle 2. Each memory wait state adds one cycle.
- Store lanes:
  - byte: wr=0001<<addr[1:0], data={4{wdata[7:0]}}
  - half: wr=0011<<addr[1:0], data={2{wdata[15:0]}}
  - word: wr=1111, data=wdata
- Load extract: shift dmem_in_data right by 8*addr[1:0], take byte or half, then extend per exs_mem_signed. Word loads pass through unchanged.
- Back-to-back: a new request seen in IDLE the cycle after DONE/FAULT is accepted normally.
- rst in any state, including BUSY with dmem_en=1: next cycle IDLE with dmem_en=0. The in-flight access is abandoned, and a late dmem_ready in IDLE is ignored.
- exs_mem_en dropping while BUSY is not legal; the access completes regardless.

Test Plan:
- Signed byte load: addr=0x103, size=00, signed=1, dmem_in_data=0x80AA_BBCC, ready on first BUSY cycle -> dmem_addr=0x100, dmem_wr=0000, lsu_rdata=0xFFFF_FF80, lsu_done at cycle 2, lsu_stall=1 for cycles 0–1.
- Half store: addr=0x22, size=01, wdata=0x1234_ABCD, 3 wait states -> dmem_wr=1100, dmem_out_data=0xABCD_ABCD, dmem_en high 4 cycles, lsu_done at cycle 5.
- Misaligned word load: addr=0x41, size=10 -> dmem_en never asserts, lsu_exc_misaligned_ld=1 at cycle 1, lsu_exc_addr=0x41, lsu_stall=0 that cycle. Repeat with size=11 store -> lsu_exc_misaligned_st.
- Bus error: word store at 0x80, dmem_ready=1 and dmem_error=1 on 2nd BUSY cycle -> lsu_exc_access pulse, lsu_exc_addr=0x80, no lsu_done.
- Timeout: TIMEOUT_CYCLES=4, ready never asserted -> dmem_en high exactly 4 cycles, then lsu_exc_access. Second run with ready on the 4th cycle -> lsu_done, no fault.
- Reset mid-access: rst during the 2nd BUSY cycle -> next cycle all outputs at reset values; a subsequent late dmem_ready produces no lsu_done; the next aligned request completes normally.
